nco_poly: RTL and testbench

//  Polyphonic numerically-controlled oscillator, parametrised successor to the single-voice NCO.

---
 rtl/nco_poly_if.sv | 24 ++
 rtl/nco_poly.sv | 253 +++++++++++++++++++++++++
 tb/tb_nco_poly.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nco_poly_if.sv
// Control/status bundle between the note/gate logic and the polyphonic NCO.
// The master drives note writes and the waveform select; the slave (the NCO) returns samples.
interface nco_poly_if #(
   parameter int VW = 2
);
   logic          NOTE_WE;
   logic [VW-1:0] NOTE_CH;
   logic [6:0]    NOTE_NUM;
   logic          NOTE_GATE;
   logic [6:0]    WAVE_SEL;
   logic          SAMPLE_STB;
   logic [7:0]    OUTPUT;
   logic          OVERRUN;

   modport master (
      output NOTE_WE, NOTE_CH, NOTE_NUM, NOTE_GATE, WAVE_SEL,
      input  SAMPLE_STB, OUTPUT, OVERRUN
   );

   modport slave (
      input  NOTE_WE, NOTE_CH, NOTE_NUM, NOTE_GATE, WAVE_SEL,
      output SAMPLE_STB, OUTPUT, OVERRUN
   );
endinterface

// File: rtl/nco_poly.sv
// Polyphonic NCO: VOICES phase accumulators scanned once per sample tick through
// shared step/sample ROMs, mixed into one unsigned 8-bit sample.

// MIDI note -> 16-bit phase step; top octave is an equal-tempered table, lower
// octaves are the same table shifted right.
module nco_step_rom (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ce_i,
   input  logic [6:0]  addr_i,
   output logic [15:0] data_o
);
   function automatic logic [15:0] step_of(input logic [6:0] n);
      logic [6:0]  oct;
      logic [6:0]  semi;
      logic [15:0] base;
      oct  = n / 7'd12;
      semi = n - oct * 7'd12;
      case (semi)
         7'd0:    base = 16'd32768;
         7'd1:    base = 16'd34716;
         7'd2:    base = 16'd36781;
         7'd3:    base = 16'd38968;
         7'd4:    base = 16'd41285;
         7'd5:    base = 16'd43740;
         7'd6:    base = 16'd46341;
         7'd7:    base = 16'd49097;
         7'd8:    base = 16'd52016;
         7'd9:    base = 16'd55109;
         7'd10:   base = 16'd58386;
         default: base = 16'd61858;
      endcase
      return base >> (7'd10 - oct);
   endfunction

   logic [15:0] data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     data_q <= '0;
      else if (ce_i) data_q <= step_of(addr_i);
   end

   assign data_o = data_q;
endmodule

// Waveform ROM: A1[1:0] picks saw/square/triangle/reverse-saw, A1[2] inverts,
// A1[6:3] rotates the phase in 1/16-cycle steps.
module nco_sample_rom (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ce_i,
   input  logic [6:0] a0_i,
   input  logic [6:0] a1_i,
   output logic [7:0] data_o
);
   function automatic logic [7:0] shape(input logic [6:0] ph, input logic [6:0] w);
      logic [6:0] p;
      logic [7:0] s;
      p = ph + {w[6:3], 3'b000};
      case (w[1:0])
         2'd0:    s = {p, 1'b0};
         2'd1:    s = {8{p[6]}};
         2'd2:    s = p[6] ? ~{p[5:0], 2'b00} : {p[5:0], 2'b00};
         default: s = ~{p, 1'b0};
      endcase
      return w[2] ? ~s : s;
   endfunction

   logic [7:0] data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     data_q <= '0;
      else if (ce_i) data_q <= shape(a0_i, a1_i);
   end

   assign data_o = data_q;
endmodule

// One voice: note, gate and phase state. A note write that opens the gate
// restarts the phase and overrides an accumulate landing on the same edge.
module nco_voice #(
   parameter int PHASE_W = 24
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wr_i,
   input  logic [6:0]  note_i,
   input  logic        gate_i,
   input  logic        acc_i,
   input  logic [15:0] step_i,
   output logic [6:0]  note_o,
   output logic        gate_o,
   output logic [6:0]  ptop_o
);
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [6:0]         note_q, note_d;
   logic               gate_q, gate_d;

   always_comb begin
      phase_d = phase_q;
      note_d  = note_q;
      gate_d  = gate_q;
      if (acc_i && gate_q) phase_d = phase_q + PHASE_W'(step_i);
      if (wr_i) begin
         note_d = note_i;
         gate_d = gate_i;
         if (gate_i && !gate_q) phase_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         phase_q <= '0;
         note_q  <= '0;
         gate_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         note_q  <= note_d;
         gate_q  <= gate_d;
      end
   end

   assign note_o = note_q;
   assign gate_o = gate_q;
   assign ptop_o = phase_q[PHASE_W-1 -: 7];
endmodule

module nco_poly #(
   parameter int VOICES     = 4,
   parameter int SAMPLE_DIV = 2268,
   parameter int DIV_W      = 12,
   parameter int PHASE_W    = 24,
   parameter int VW         = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   nco_poly_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, STEP, ACC, MIX, OUT} state_e;

   state_e                  state_q, state_d;
   logic [DIV_W-1:0]        cnt_q, cnt_d;
   logic                    tick;
   logic [VW-1:0]           v_q, v_d;
   logic [VW+7:0]           acc_q, acc_d, acc_sum;
   logic [7:0]              out_q, out_d;
   logic                    ovr_q, ovr_d;
   logic                    step_ce, smp_ce;
   logic [15:0]             step_w;
   logic [7:0]              smp_w;
   logic [VOICES-1:0]       wr_w, acc_en_w, gate_w;
   logic [VOICES-1:0][6:0]  note_w, ptop_w;

   assign tick  = (cnt_q == DIV_W'(SAMPLE_DIV - 1));
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   for (genvar i = 0; i < VOICES; i++) begin : g_voice
      assign wr_w[i]     = bus.NOTE_WE && (bus.NOTE_CH == VW'(i));
      assign acc_en_w[i] = (state_q == ACC) && (v_q == VW'(i));
      nco_voice #(.PHASE_W(PHASE_W)) u_voice (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .wr_i   (wr_w[i]),
         .note_i (bus.NOTE_NUM),
         .gate_i (bus.NOTE_GATE),
         .acc_i  (acc_en_w[i]),
         .step_i (step_w),
         .note_o (note_w[i]),
         .gate_o (gate_w[i]),
         .ptop_o (ptop_w[i])
      );
   end

   nco_step_rom u_step_rom (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .ce_i   (step_ce),
      .addr_i (note_w[v_q]),
      .data_o (step_w)
   );

   nco_sample_rom u_sample_rom (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .ce_i   (smp_ce),
      .a0_i   (ptop_w[v_q]),
      .a1_i   (bus.WAVE_SEL),
      .data_o (smp_w)
   );

   // A muted voice contributes the midpoint so it is silent in the mix.
   assign acc_sum = acc_q + (VW+8)'(gate_w[v_q] ? smp_w : 8'h80);

   always_comb begin
      state_d = state_q;
      v_d     = v_q;
      acc_d   = acc_q;
      out_d   = out_q;
      ovr_d   = ovr_q;
      step_ce = 1'b0;
      smp_ce  = 1'b0;
      if (tick && state_q != IDLE) ovr_d = 1'b1;
      case (state_q)
         IDLE: if (tick) begin
            v_d     = '0;
            acc_d   = '0;
            state_d = STEP;
         end
         STEP: begin
            step_ce = 1'b1;
            state_d = ACC;
         end
         ACC: begin
            smp_ce  = 1'b1;
            state_d = MIX;
         end
         MIX: begin
            acc_d = acc_sum;
            if (v_q == VW'(VOICES - 1)) begin
               out_d   = acc_sum[VW+7:VW];
               state_d = OUT;
            end else begin
               v_d     = v_q + 1'b1;
               state_d = STEP;
            end
         end
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         v_q     <= '0;
         acc_q   <= '0;
         out_q   <= 8'h80;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         v_q     <= v_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.SAMPLE_STB = (state_q == OUT);
   assign bus.OUTPUT     = out_q;
   assign bus.OVERRUN    = ovr_q;
endmodule

// File: tb/tb_nco_poly.sv
// Bench for nco_poly: vector table, hand-built corner sequences and random note
// traffic checked every cycle against a scan-level model.
module tb_nco_poly;
   localparam int V  = 2;
   localparam int SD = 16;

   logic clk, rst, rst2;
   nco_poly_if #(.VW(1)) bus ();
   nco_poly_if #(.VW(1)) bus2 ();

   nco_poly #(.VOICES(V), .SAMPLE_DIV(SD), .DIV_W(12), .PHASE_W(24), .VW(1)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus));
   nco_poly #(.VOICES(V), .SAMPLE_DIV(6), .DIV_W(12), .PHASE_W(24), .VW(1)) dut_ovr (
      .clk_i(clk), .rst_i(rst2), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0, passes = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int base_tab[12] = '{32768, 34716, 36781, 38968, 41285, 43740,
                        46341, 49097, 52016, 55109, 58386, 61858};

   function automatic int step_rom(input int n);
      return base_tab[n % 12] >> (10 - n / 12);
   endfunction

   function automatic int wave(input int ph, input int w);
      int p, s;
      p = (ph + 8 * (w / 8)) % 128;
      case (w % 4)
         0:       s = 2 * p;
         1:       s = (p >= 64) ? 255 : 0;
         2:       s = (p < 64) ? 4 * p : 255 - 4 * (p - 64);
         default: s = 255 - 2 * p;
      endcase
      if ((w / 4) % 2 == 1) s = 255 - s;
      return s;
   endfunction

   int          e, scan_t, acc, smp, out_exp;
   bit          busy, stb_exp, ovr_exp;
   int          m_note[V], m_gate[V], stp[V];
   int unsigned m_phase[V];

   task automatic model_reset();
      e = 0; busy = 0; stb_exp = 0; ovr_exp = 0; out_exp = 'h80; acc = 0; smp = 0;
      for (int v = 0; v < V; v++) begin
         m_note[v] = 0; m_gate[v] = 0; m_phase[v] = 0; stp[v] = 0;
      end
   endtask

   // Advance the model across one clock edge using the inputs presented to it.
   task automatic model_edge();
      bit was_busy;
      int k, ch;
      was_busy = busy;
      e++;
      stb_exp = 0;
      if (busy) begin
         k = e - scan_t;
         for (int v = 0; v < V; v++) begin
            if (k == 3 * v + 1) stp[v] = step_rom(m_note[v]);
            if (k == 3 * v + 2) begin
               smp = wave(int'(m_phase[v] >> 17), int'(bus.WAVE_SEL));
               if (m_gate[v] != 0) m_phase[v] = (m_phase[v] + stp[v]) % (1 << 24);
            end
            if (k == 3 * v + 3) acc += (m_gate[v] != 0) ? smp : 128;
         end
         if (k == 3 * V) begin
            stb_exp = 1;
            out_exp = acc / V;
         end
         if (k == 3 * V + 1) busy = 0;
      end
      if (e % SD == 0) begin
         if (was_busy) ovr_exp = 1;
         else begin
            busy = 1; scan_t = e; acc = 0;
         end
      end
      if (bus.NOTE_WE) begin
         ch = int'(bus.NOTE_CH);
         if (bus.NOTE_GATE && m_gate[ch] == 0) m_phase[ch] = 0;
         m_note[ch] = int'(bus.NOTE_NUM);
         m_gate[ch] = int'(bus.NOTE_GATE);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      chk("stb", int'(bus.SAMPLE_STB), int'(stb_exp));
      chk("output", int'(bus.OUTPUT), out_exp);
      chk("overrun", int'(bus.OVERRUN), int'(ovr_exp));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.NOTE_WE = 1'b0; bus.NOTE_CH = 1'b0; bus.NOTE_NUM = '0; bus.NOTE_GATE = 1'b0;
      bus.WAVE_SEL = '0;
      #1;
      chk("reset_stb", int'(bus.SAMPLE_STB), 0);
      chk("reset_output", int'(bus.OUTPUT), 'h80);
      chk("reset_overrun", int'(bus.OVERRUN), 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic wr(input int ch, input int note, input int gate);
      bus.NOTE_WE = 1'b1; bus.NOTE_CH = 1'(ch); bus.NOTE_NUM = 7'(note); bus.NOTE_GATE = 1'(gate);
      cyc();
      bus.NOTE_WE = 1'b0;
   endtask

   task automatic wait_stb(input int n, input string name);
      int seen, budget;
      seen = 0;
      budget = (n + 1) * SD + 40;
      while (seen < n && budget > 0) begin
         cyc();
         if (bus.SAMPLE_STB) seen++;
         budget--;
      end
      chk({name, "_strobes"}, seen, n);
   endtask

   task automatic wait_k(input int kk);
      bit reached;
      reached = 0;
      for (int n = 0; n < 3 * SD && !reached; n++) begin
         cyc();
         if (busy && (e - scan_t) == kk) reached = 1;
      end
      chk("scan_phase_reached", int'(reached), 1);
   endtask

   typedef struct {
      int note; int gate; int wave; int scan; int exp;
   } vec_t;
   vec_t tv[8];

   int ostart, n_stb;
   bit oexp, got;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // {note, gate, wave, scan index, OUTPUT of that scan}; voice 1 stays muted.
      tv[0] = '{127, 1, 0,    0, 'h40};
      tv[1] = '{127, 1, 3,    0, 'hBF};
      tv[2] = '{127, 1, 0,    3, 'h41};
      tv[3] = '{127, 1, 1,  200, 'hBF};
      tv[4] = '{127, 1, 0,  400, 'h55};   // phase has wrapped past 2**24
      tv[5] = '{  0, 0, 2,    5, 'h80};
      tv[6] = '{ 69, 1, 2,  100, 'h42};
      tv[7] = '{ 60, 1, 4, 1000, 'hB8};

      rst = 1'b1; rst2 = 1'b1;
      bus.NOTE_WE = 1'b0; bus.NOTE_CH = 1'b0; bus.NOTE_NUM = '0; bus.NOTE_GATE = 1'b0; bus.WAVE_SEL = '0;
      bus2.NOTE_WE = 1'b0; bus2.NOTE_CH = 1'b0; bus2.NOTE_NUM = '0; bus2.NOTE_GATE = 1'b0; bus2.WAVE_SEL = '0;
      model_reset();

      // Overrun: a 7-cycle scan against a 6-cycle tick period.
      repeat (2) @(negedge clk);
      rst2 = 1'b0;
      ostart = -100; oexp = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         if (n % 6 == 0) begin
            if (n <= ostart + 3 * V + 1) oexp = 1;
            else ostart = n;
         end
         @(negedge clk);
         chk("overrun_sticky", int'(bus2.OVERRUN), int'(oexp));
      end
      rst2 = 1'b1;
      #1;
      chk("overrun_cleared_by_rst", int'(bus2.OVERRUN), 0);

      // Silent start: first strobe timing and midpoint output.
      do_reset();
      got = 0;
      for (int n = 0; n < 60 && !got; n++) begin
         cyc();
         if (bus.SAMPLE_STB) got = 1;
      end
      chk("first_stb_cycle", e + 1, SD + 3 * V + 1);
      chk("silent_output", int'(bus.OUTPUT), 'h80);
      wait_stb(3, "silent");

      // Vector table.
      for (int i = 0; i < 8; i++) begin
         do_reset();
         bus.WAVE_SEL = 7'(tv[i].wave);
         wr(0, tv[i].note, tv[i].gate);
         wait_stb(tv[i].scan + 1, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_output", i), int'(bus.OUTPUT), tv[i].exp);
      end

      // Reset asserted while voice 1 is in MIX.
      do_reset();
      bus.WAVE_SEL = 7'd2;
      wr(0, 127, 1);
      wr(1, 100, 1);
      wait_stb(2, "pre_rst");
      wait_k(5);
      rst = 1'b1;
      #1;
      chk("midscan_rst_stb", int'(bus.SAMPLE_STB), 0);
      chk("midscan_rst_output", int'(bus.OUTPUT), 'h80);
      chk("midscan_rst_overrun", int'(bus.OVERRUN), 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      bus.WAVE_SEL = '0;
      wr(0, 127, 1);
      wait_stb(1, "post_rst");
      chk("post_rst_first_stb", e + 1, SD + 3 * V + 1);
      chk("post_rst_output", int'(bus.OUTPUT), 'h40);

      // Gate-open write landing on the same edge as voice 1's accumulate.
      do_reset();
      wr(1, 127, 1);
      wait_stb(100, "build_phase");
      wr(1, 127, 0);
      wait_k(4);
      wr(1, 127, 1);
      wait_stb(2, "collision");
      chk("collision_phase_reset", int'(bus.OUTPUT), 'h40);

      // Waveform change between the two voices' ACC cycles.
      do_reset();
      wr(0, 127, 1);
      wr(1, 127, 1);
      wait_k(3);
      bus.WAVE_SEL = 7'd5;
      wait_stb(1, "wave_split");
      chk("wave_split_output", int'(bus.OUTPUT), 'h7F);

      // Random note/gate/waveform traffic.
      do_reset();
      n_stb = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            bus.NOTE_WE   = 1'b1;
            bus.NOTE_CH   = 1'($urandom_range(0, 1));
            bus.NOTE_NUM  = 7'($urandom_range(0, 127));
            bus.NOTE_GATE = ($urandom_range(0, 3) != 0);
         end else begin
            bus.NOTE_WE = 1'b0;
         end
         if ($urandom_range(0, 19) == 0) bus.WAVE_SEL = 7'($urandom_range(0, 127));
         cyc();
         if (bus.SAMPLE_STB) n_stb++;
      end
      bus.NOTE_WE = 1'b0;
      chk("random_strobe_count", n_stb, 3000 / SD);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
